// File: rtl/pdm_interp.sv
// Audio-rate to clk-rate feeder for the PDM modulator: 2-entry sample FIFO,
// linear interpolation between consecutive samples, volume gain and saturation.
module pdm_interp #(
    parameter int INTERP_LOG2 = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] smpl_in,
    input  logic               smpl_vld,
    output logic               smpl_rdy,
    input  logic [7:0]         volume,
    output logic signed [15:0] duty,
    output logic               underrun,
    input  logic               underrun_clr
);
    localparam int L  = INTERP_LOG2;
    localparam int PW = INTERP_LOG2 + 18;
    localparam logic [L-1:0] PHASE_MAX = {L{1'b1}};
    localparam logic [L-1:0] PHASE_ONE = {{(L-1){1'b0}}, 1'b1};

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sh07FFF) begin
            sat16 = 16'sh7FFF;
        end else if (v < 17'sh18000) begin
            sat16 = 16'sh8000;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

    logic [L-1:0]          phase_r;
    logic [1:0]            count_r;
    logic [1:0]            count_s;
    logic                  rd_ptr_r;
    logic                  wr_ptr_r;
    logic signed [15:0]    fifo_r [2];
    logic signed [15:0]    cur_r;
    logic signed [15:0]    nxt_r;
    logic                  smpl_rdy_r;
    logic                  underrun_r;
    logic signed [15:0]    duty_r;

    logic                  wrap_s;
    logic                  push_s;
    logic                  pop_s;
    logic signed [16:0]    diff_s;
    logic signed [L:0]     phase_sx_s;
    logic signed [PW-1:0]  slope_s;
    logic signed [15:0]    interp_s;
    logic signed [23:0]    gain_prod_s;
    logic signed [16:0]    scaled_s;

    assign smpl_rdy = smpl_rdy_r;
    assign underrun = underrun_r;
    assign duty     = duty_r;

    // FIFO handshake decode; the pop test uses the occupancy before any same-cycle push
    always_comb begin
        wrap_s  = (phase_r == PHASE_MAX);
        push_s  = smpl_vld && smpl_rdy_r;
        pop_s   = wrap_s && (count_r != 2'd0);
        count_s = count_r;
        if (push_s && !pop_s) begin
            count_s = count_r + 2'd1;
        end else if (pop_s && !push_s) begin
            count_s = count_r - 2'd1;
        end else begin
            count_s = count_r;
        end
    end

    // Interpolation and gain datapath; the 17-bit difference keeps full-scale swings exact
    always_comb begin
        diff_s      = {nxt_r[15], nxt_r} - {cur_r[15], cur_r};
        phase_sx_s  = {1'b0, phase_r};
        slope_s     = PW'(diff_s) * PW'(phase_sx_s);
        interp_s    = 16'(PW'(cur_r) + (slope_s >>> L));
        gain_prod_s = 24'(interp_s) * 24'($signed({1'b0, volume}));
        scaled_s    = 17'(gain_prod_s >>> 7);
    end

    // Free-running phase counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= '0;
        end else begin
            phase_r <= phase_r + PHASE_ONE;
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_r[0]  <= 16'sd0;
            fifo_r[1]  <= 16'sd0;
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            smpl_rdy_r <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= smpl_in;
                wr_ptr_r         <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r    <= count_s;
            smpl_rdy_r <= (count_s != 2'd2);
        end
    end

    // Segment endpoints advance on the wrap; an empty FIFO holds nxt and flags underrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_r      <= 16'sd0;
            nxt_r      <= 16'sd0;
            underrun_r <= 1'b0;
        end else begin
            if (wrap_s) begin
                cur_r <= nxt_r;
                if (pop_s) begin
                    nxt_r <= fifo_r[rd_ptr_r];
                end
            end
            if (wrap_s && (count_r == 2'd0)) begin
                underrun_r <= 1'b1;
            end else if (underrun_clr) begin
                underrun_r <= 1'b0;
            end
        end
    end

    // Registered, saturated output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r <= 16'sd0;
        end else begin
            duty_r <= sat16(scaled_s);
        end
    end

endmodule

// File: tb/tb_pdm_interp.sv
// Self-checking bench for pdm_interp (INTERP_LOG2 = 4): cycle scoreboard from an
// integer reference model, a gain/saturation vector table and directed corner sequences.
module tb_pdm_interp;
    localparam int L      = 4;
    localparam int PERIOD = 16;

    logic               clk          = 1'b0;
    logic               rst_n        = 1'b0;
    logic signed [15:0] smpl_in      = 16'sd0;
    logic               smpl_vld     = 1'b0;
    logic               smpl_rdy;
    logic [7:0]         volume       = 8'd128;
    logic signed [15:0] duty;
    logic               underrun;
    logic               underrun_clr = 1'b0;

    always #5 clk = ~clk;

    pdm_interp #(.INTERP_LOG2(L)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .smpl_in      (smpl_in),
        .smpl_vld     (smpl_vld),
        .smpl_rdy     (smpl_rdy),
        .volume       (volume),
        .duty         (duty),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    int m_phase;
    int m_cur;
    int m_nxt;
    int m_fifo[$];
    bit m_und;

    typedef struct {
        int sample;
        int vol;
        int exp_duty;
    } vec_t;
    vec_t vecs[10];

    function automatic int floor_div(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int model_duty();
        int interp;
        int scaled;
        interp = m_cur + floor_div((m_nxt - m_cur) * m_phase, PERIOD);
        scaled = floor_div(interp * int'(volume), 128);
        if (scaled > 32767) return 32767;
        if (scaled < -32768) return -32768;
        return scaled;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: predict, advance the model, then compare after the edge
    task automatic tick();
        bit push;
        bit wrap;
        bit empty;
        int e;
        exp_q.push_back(model_duty());
        empty = (m_fifo.size() == 0);
        push  = smpl_vld && (m_fifo.size() != 2);
        wrap  = (m_phase == PERIOD - 1);
        if (wrap) begin
            m_cur = m_nxt;
            if (!empty) m_nxt = m_fifo.pop_front();
        end
        if (wrap && empty) m_und = 1'b1;
        else if (underrun_clr) m_und = 1'b0;
        if (push) m_fifo.push_back(int'(smpl_in));
        m_phase = (m_phase + 1) % PERIOD;
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("duty", int'(duty), e);
        check("smpl_rdy", int'(smpl_rdy), int'(m_fifo.size() != 2));
        check("underrun", int'(underrun), int'(m_und));
    endtask

    task automatic run_until_phase(input int ph, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (m_phase == ph) break;
            tick();
        end
        check("wait_phase", m_phase, ph);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        smpl_vld     = 1'b0;
        underrun_clr = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("rst_duty", int'(duty), 0);
        check("rst_rdy", int'(smpl_rdy), 1);
        check("rst_underrun", int'(underrun), 0);
        m_phase = 0;
        m_cur   = 0;
        m_nxt   = 0;
        m_und   = 1'b0;
        m_fifo.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int accepted;
        int seq;
        bit acc;

        vecs[0] = '{32767, 255, 32767};
        vecs[1] = '{-32768, 255, -32768};
        vecs[2] = '{1000, 255, 1992};
        vecs[3] = '{1000, 64, 500};
        vecs[4] = '{-1001, 64, -501};
        vecs[5] = '{1000, 0, 0};
        vecs[6] = '{1000, 128, 1000};
        vecs[7] = '{100, 200, 156};
        vecs[8] = '{-100, 200, -157};
        vecs[9] = '{-32768, 128, -32768};

        @(negedge clk);
        do_reset();

        // Ramp: 0 -> 1600 -> 3200 at unity gain
        volume   = 8'd128;
        smpl_vld = 1'b1;
        smpl_in  = 16'sd1600;
        tick();
        smpl_in  = 16'sd3200;
        tick();
        smpl_vld = 1'b0;
        run_until_phase(0, 20);
        for (int p = 0; p < PERIOD; p++) begin
            tick();
            check("ramp_seg1", int'(duty), 100 * p);
        end
        for (int p = 0; p < PERIOD; p++) begin
            tick();
            check("ramp_seg2", int'(duty), 1600 + 100 * p);
        end
        repeat (20) tick();
        check("ramp_final", int'(duty), 3200);

        // Gain and saturation table with a constant held sample
        for (int i = 0; i < 10; i++) begin
            do_reset();
            volume   = 8'(vecs[i].vol);
            smpl_in  = 16'(vecs[i].sample);
            smpl_vld = 1'b1;
            repeat (50) tick();
            check($sformatf("gain_vec%0d", i), int'(duty), vecs[i].exp_duty);
        end
        smpl_vld = 1'b0;

        // Backpressure with an incrementing sequence
        do_reset();
        volume   = 8'd128;
        smpl_vld = 1'b1;
        seq      = 1;
        smpl_in  = 16'sd1000;
        accepted = 0;
        repeat (100) begin
            acc = smpl_rdy;
            tick();
            if (acc) begin
                accepted++;
                seq++;
                smpl_in = 16'(seq * 1000);
            end
        end
        check("bp_accepted", accepted, 8);
        check("bp_duty", int'(duty), 5187);
        smpl_vld = 1'b0;

        // Underrun after the last sample, then clear behaviour
        do_reset();
        volume   = 8'd128;
        smpl_vld = 1'b1;
        smpl_in  = 16'sd500;
        tick();
        smpl_vld = 1'b0;
        run_until_phase(PERIOD - 1, 20);
        tick();
        check("und_first_wrap", int'(underrun), 0);
        run_until_phase(PERIOD - 1, 20);
        tick();
        check("und_set", int'(underrun), 1);
        repeat (20) tick();
        check("und_flat", int'(duty), 500);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("und_clr", int'(underrun), 0);
        run_until_phase(PERIOD - 1, 20);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check("und_clr_on_wrap", int'(underrun), 1);

        // Async reset mid-segment with a full FIFO and the flag set
        do_reset();
        volume = 8'd128;
        repeat (20) tick();
        smpl_vld = 1'b1;
        smpl_in  = 16'sd1000;
        repeat (30) tick();
        run_until_phase(7, 20);
        check("pre_rst_duty", int'(duty), 1000);
        check("pre_rst_rdy", int'(smpl_rdy), 0);
        check("pre_rst_und", int'(underrun), 1);
        do_reset();
        run_until_phase(PERIOD - 1, 20);
        check("post_rst_und_before_wrap", int'(underrun), 0);
        tick();
        check("post_rst_und_at_wrap", int'(underrun), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
